mul_err_stats: RTL



---
 rtl/mul_err_stats_pkg.sv | 16 +
 rtl/mul_err_calc.sv | 60 ++++++
 rtl/mul_err_stats.sv | 105 ++++++++++
 3 files changed

// File: rtl/mul_err_stats_pkg.sv
// mul_err_stats_pkg: state encoding and width helpers shared by the error-statistics block
package mul_err_stats_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
    function automatic int prod_w(input int w);
        return 2 * w + 1;
    endfunction
    function automatic int abs_w(input int w);
        return 2 * w + 1;
    endfunction
    function automatic int sum_w(input int w, input int s);
        return 2 * w + 1 + s;
    endfunction
    function automatic int bias_w(input int w, input int s);
        return 2 * w + 2 + s;
    endfunction
endpackage

// File: rtl/mul_err_calc.sv
// mul_err_calc: 2-stage exact-product / absolute-error pipeline; MUL_ERR_STATS_BIAS_EN also exports the signed error
module mul_err_calc import mul_err_stats_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [WIDTH-1:0]                in1,
    input  logic [WIDTH-1:0]                in2,
    input  logic [prod_w(WIDTH)-1:0]        approx_in,
`ifdef MUL_ERR_STATS_BIAS_EN
    output logic signed [prod_w(WIDTH):0]   diff_err,
`endif
    output logic                            out_valid,
    output logic [abs_w(WIDTH)-1:0]         abs_err,
    output logic                            neq
);
    localparam int PW = prod_w(WIDTH);
    logic              s1_v_q, s1_v_d, s2_v_q, s2_v_d, neq_q, neq_d;
    logic [PW-1:0]     exact_q, exact_d, approx_q, approx_d, abs_q, abs_d;
    logic [2*WIDTH-1:0] prod;
    logic signed [PW:0] diff, diff_q, diff_d;
    always_comb begin
        prod     = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};
        s1_v_d   = in_valid;
        exact_d  = {1'b0, prod};
        approx_d = approx_in;
        diff     = $signed({1'b0, approx_q}) - $signed({1'b0, exact_q});
        s2_v_d   = s1_v_q;
        abs_d    = PW'(diff[PW] ? -diff : diff);
        neq_d    = |abs_d;
        diff_d   = diff;
    end
    // valid bits are the only state that matters on reset, but clearing everything keeps outputs tidy
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            exact_q  <= '0;
            approx_q <= '0;
            abs_q    <= '0;
            neq_q    <= 1'b0;
            diff_q   <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s2_v_q   <= s2_v_d;
            exact_q  <= exact_d;
            approx_q <= approx_d;
            abs_q    <= abs_d;
            neq_q    <= neq_d;
            diff_q   <= diff_d;
        end
    end
    assign out_valid = s2_v_q;
    assign abs_err   = abs_q;
    assign neq       = neq_q;
`ifdef MUL_ERR_STATS_BIAS_EN
    assign diff_err  = diff_q;
`endif
endmodule

// File: rtl/mul_err_stats.sv
// mul_err_stats: windowed error statistics for an approximate multiplier; MUL_ERR_STATS_BIAS_EN adds a signed-error sum
module mul_err_stats import mul_err_stats_pkg::*; #(
    parameter int WIDTH        = 8,
    parameter int SAMPLES_LOG2 = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [WIDTH-1:0]                              in1,
    input  logic [WIDTH-1:0]                              in2,
    input  logic [prod_w(WIDTH)-1:0]                      approx_out,
    output logic                                          busy,
    output logic                                          done,
    output logic [SAMPLES_LOG2:0]                         sample_count,
    output logic [SAMPLES_LOG2:0]                         err_count,
    output logic [sum_w(WIDTH, SAMPLES_LOG2)-1:0]         sum_abs_err,
`ifdef MUL_ERR_STATS_BIAS_EN
    output logic signed [bias_w(WIDTH, SAMPLES_LOG2)-1:0] sum_signed_err,
`endif
    output logic [abs_w(WIDTH)-1:0]                       max_abs_err
);
    localparam int CW = SAMPLES_LOG2 + 1;
    localparam int AW = abs_w(WIDTH);
    localparam int SW = sum_w(WIDTH, SAMPLES_LOG2);
    localparam int N  = 1 << SAMPLES_LOG2;
    state_e          state_q, state_d;
    logic [CW-1:0]   acc_cnt_q, acc_cnt_d, sample_count_q, sample_count_d, err_count_q, err_count_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [AW-1:0]   max_q, max_d, abs_err;
    logic            accept, clr, s2_valid, neq;
`ifdef MUL_ERR_STATS_BIAS_EN
    localparam int BW = bias_w(WIDTH, SAMPLES_LOG2);
    logic signed [prod_w(WIDTH):0] diff_err;
    logic signed [BW-1:0]          bias_q, bias_d;
`endif
    mul_err_calc #(.WIDTH(WIDTH)) u_calc (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in1       (in1),
        .in2       (in2),
        .approx_in (approx_out),
`ifdef MUL_ERR_STATS_BIAS_EN
        .diff_err  (diff_err),
`endif
        .out_valid (s2_valid),
        .abs_err   (abs_err),
        .neq       (neq)
    );
    assign in_ready = state_q == RUN;
    assign accept   = in_valid && in_ready;
    assign clr      = start && (state_q == IDLE || state_q == DONE);
    // DRAIN ends on the edge that folds in the last sample, so done and final stats appear together
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN:        if (accept && acc_cnt_q == CW'(N - 1)) state_d = DRAIN;
            DRAIN:      if (s2_valid && sample_count_q == CW'(N - 1)) state_d = DONE;
            default:    state_d = IDLE;
        endcase
        acc_cnt_d      = clr ? '0 : acc_cnt_q + CW'(accept);
        sample_count_d = clr ? '0 : sample_count_q + CW'(s2_valid);
        err_count_d    = clr ? '0 : err_count_q + CW'(s2_valid && neq);
        sum_d          = clr ? '0 : s2_valid ? sum_q + SW'(abs_err) : sum_q;
        max_d          = clr ? '0 : (s2_valid && abs_err > max_q) ? abs_err : max_q;
`ifdef MUL_ERR_STATS_BIAS_EN
        bias_d         = clr ? '0 : s2_valid ? bias_q + BW'(diff_err) : bias_q;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            acc_cnt_q      <= '0;
            sample_count_q <= '0;
            err_count_q    <= '0;
            sum_q          <= '0;
            max_q          <= '0;
`ifdef MUL_ERR_STATS_BIAS_EN
            bias_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            acc_cnt_q      <= acc_cnt_d;
            sample_count_q <= sample_count_d;
            err_count_q    <= err_count_d;
            sum_q          <= sum_d;
            max_q          <= max_d;
`ifdef MUL_ERR_STATS_BIAS_EN
            bias_q         <= bias_d;
`endif
        end
    end
    assign busy         = state_q == RUN || state_q == DRAIN;
    assign done         = state_q == DONE;
    assign sample_count = sample_count_q;
    assign err_count    = err_count_q;
    assign sum_abs_err  = sum_q;
    assign max_abs_err  = max_q;
`ifdef MUL_ERR_STATS_BIAS_EN
    assign sum_signed_err = bias_q;
`endif
endmodule
